// File: rtl/rename_map_table_ckpt.sv
// rtl/rename_map_table_ckpt.sv - N-wide rename map table with circular branch checkpoint pool
// Optional ROB walk recovery ports are added when RMT_WALK_RECOVERY_EN is defined.
module rename_map_table_ckpt #(
    parameter int ARCH_REGS = 32,
    parameter int PRF_W     = 6,
    parameter int RN_WIDTH  = 2,
    parameter int NUM_CKPT  = 8,
    localparam int AREG_W   = $clog2(ARCH_REGS),
    localparam int CKPT_W   = $clog2(NUM_CKPT),
    localparam int SLOT_W   = (RN_WIDTH > 1) ? $clog2(RN_WIDTH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RN_WIDTH-1:0]                rn_valid,
    input  logic [RN_WIDTH-1:0][AREG_W-1:0]    rn_rd,
    input  logic [RN_WIDTH-1:0][AREG_W-1:0]    rn_rs1,
    input  logic [RN_WIDTH-1:0][AREG_W-1:0]    rn_rs2,
    input  logic [RN_WIDTH-1:0]                rn_wen,
    input  logic [RN_WIDTH-1:0][PRF_W-1:0]     rn_new_prf,
    output logic [RN_WIDTH-1:0][PRF_W-1:0]     rn_rs1_prf,
    output logic [RN_WIDTH-1:0][PRF_W-1:0]     rn_rs2_prf,
    output logic [RN_WIDTH-1:0][PRF_W-1:0]     rn_rd_stale_prf,
    input  logic                               ckpt_req,
    input  logic [SLOT_W-1:0]                  ckpt_slot,
    output logic [CKPT_W-1:0]                  ckpt_id,
    output logic                               rn_ready,
    input  logic                               br_mispredict,
    input  logic [CKPT_W-1:0]                  br_ckpt_id,
    input  logic                               ckpt_release,
`ifdef RMT_WALK_RECOVERY_EN
    input  logic                               walk_mode,
    input  logic [RN_WIDTH-1:0]                walk_valid,
    input  logic [RN_WIDTH-1:0][AREG_W-1:0]    walk_arf,
    input  logic [RN_WIDTH-1:0][PRF_W-1:0]     walk_prf,
`endif
    output logic [CKPT_W:0]                    ckpt_count
);

    typedef logic [ARCH_REGS-1:0][PRF_W-1:0] map_t;

    map_t              map_q, map_d, map_upd, snap, walk_map;
    map_t              ckpt_q [NUM_CKPT];
    logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d, restore_cnt, live_off;
    logic [CKPT_W:0]   count_q, count_d;
    logic [RN_WIDTH-1:0] wr_en;
    logic              full, rel, alloc, walk;

`ifdef RMT_WALK_RECOVERY_EN
    assign walk = walk_mode;
`else
    assign walk = 1'b0;
`endif

    assign full     = (count_q == (CKPT_W+1)'(NUM_CKPT));
    assign rn_ready = ~br_mispredict & ~walk & ~(ckpt_req & full);
    assign rel      = ckpt_release & (count_q != '0);
    assign alloc    = rn_ready & ckpt_req;
    assign ckpt_id    = tail_q;
    assign ckpt_count = count_q;

    // x0 is never a bypass source nor a map write target
    always_comb begin
        for (int j = 0; j < RN_WIDTH; j++) begin
            wr_en[j] = rn_valid[j] & rn_wen[j] & (rn_rd[j] != '0);
        end
    end

    // Later older slots override earlier ones, so the youngest older writer wins
    always_comb begin
        for (int k = 0; k < RN_WIDTH; k++) begin
            rn_rs1_prf[k]      = map_q[rn_rs1[k]];
            rn_rs2_prf[k]      = map_q[rn_rs2[k]];
            rn_rd_stale_prf[k] = map_q[rn_rd[k]];
            for (int j = 0; j < k; j++) begin
                if (wr_en[j] && rn_rd[j] == rn_rs1[k]) rn_rs1_prf[k] = rn_new_prf[j];
                if (wr_en[j] && rn_rd[j] == rn_rs2[k]) rn_rs2_prf[k] = rn_new_prf[j];
                if (wr_en[j] && rn_rd[j] == rn_rd[k])  rn_rd_stale_prf[k] = rn_new_prf[j];
            end
        end
    end

    always_comb begin
        map_upd = map_q;
        snap    = map_q;
        for (int j = 0; j < RN_WIDTH; j++) begin
            if (wr_en[j]) begin
                map_upd[rn_rd[j]] = rn_new_prf[j];
                if (j <= int'(ckpt_slot)) snap[rn_rd[j]] = rn_new_prf[j];
            end
        end
    end

    // Walk slots are applied youngest first so the oldest slot lands last and wins
    always_comb begin
        walk_map = map_q;
`ifdef RMT_WALK_RECOVERY_EN
        for (int j = RN_WIDTH-1; j >= 0; j--) begin
            if (walk_valid[j] && walk_arf[j] != '0) walk_map[walk_arf[j]] = walk_prf[j];
        end
`endif
    end

    always_comb begin
        head_d      = head_q + CKPT_W'(rel);
        restore_cnt = br_ckpt_id - head_d + CKPT_W'(1);
        map_d       = map_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (br_mispredict) begin
            map_d   = ckpt_q[br_ckpt_id];
            tail_d  = br_ckpt_id + CKPT_W'(1);
            count_d = (restore_cnt == '0 && full) ? (CKPT_W+1)'(NUM_CKPT) : {1'b0, restore_cnt};
        end else if (walk) begin
            map_d   = walk_map;
            tail_d  = head_d;
            count_d = '0;
        end else begin
            if (rn_ready) map_d = map_upd;
            tail_d  = tail_q + CKPT_W'(alloc);
            count_d = count_q + (CKPT_W+1)'(alloc) - (CKPT_W+1)'(rel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PRF_W'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            map_q   <= map_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) ckpt_q[tail_q] <= snap;
    end

    assign live_off = br_ckpt_id - head_q;

    a_restore_live: assert property (@(posedge clk) disable iff (rst)
        br_mispredict |-> ({1'b0, live_off} < count_q));

endmodule

// File: tb/tb_rename_map_table_ckpt.sv
// tb/tb_rename_map_table_ckpt.sv - randomized and directed bench for rename_map_table_ckpt
module tb_rename_map_table_ckpt;
    localparam int AW = 5, PW = 6, W = 2, NC = 8, CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]         rn_valid, rn_wen;
    logic [W-1:0][AW-1:0] rn_rd, rn_rs1, rn_rs2;
    logic [W-1:0][PW-1:0] rn_new_prf, rn_rs1_prf, rn_rs2_prf, rn_rd_stale_prf;
    logic                 ckpt_req, rn_ready, br_mispredict, ckpt_release;
    logic [0:0]           ckpt_slot;
    logic [CW-1:0]        ckpt_id, br_ckpt_id;
    logic [CW:0]          ckpt_count;
`ifdef RMT_WALK_RECOVERY_EN
    logic                 walk_mode;
    logic [W-1:0]         walk_valid;
    logic [W-1:0][AW-1:0] walk_arf;
    logic [W-1:0][PW-1:0] walk_prf;
`endif

    int checks = 0;
    int failures = 0;
    int m_map [32];
    int m_ck [8][32];
    int m_head, m_tail, m_count;

    rename_map_table_ckpt dut (
        .clk(clk), .rst(rst), .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_rs1(rn_rs1),
        .rn_rs2(rn_rs2), .rn_wen(rn_wen), .rn_new_prf(rn_new_prf), .rn_rs1_prf(rn_rs1_prf),
        .rn_rs2_prf(rn_rs2_prf), .rn_rd_stale_prf(rn_rd_stale_prf), .ckpt_req(ckpt_req),
        .ckpt_slot(ckpt_slot), .ckpt_id(ckpt_id), .rn_ready(rn_ready),
        .br_mispredict(br_mispredict), .br_ckpt_id(br_ckpt_id), .ckpt_release(ckpt_release),
`ifdef RMT_WALK_RECOVERY_EN
        .walk_mode(walk_mode), .walk_valid(walk_valid), .walk_arf(walk_arf), .walk_prf(walk_prf),
`endif
        .ckpt_count(ckpt_count)
    );

    function automatic int exp_lookup(input int k, input int src);
        int v = m_map[src];
        for (int j = 0; j < k; j++)
            if (rn_valid[j] && rn_wen[j] && int'(rn_rd[j]) == src && src != 0) v = int'(rn_new_prf[j]);
        return v;
    endfunction

    function automatic bit exp_ready();
        bit r = !br_mispredict && !(ckpt_req && m_count == NC);
`ifdef RMT_WALK_RECOVERY_EN
        r = r && !walk_mode;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = i;
        m_head = 0; m_tail = 0; m_count = 0;
    endtask

    // Reference state update from the current inputs, applied at the coming edge
    task automatic model_commit();
        bit rel = ckpt_release && m_count > 0;
        bit acc = exp_ready();
        int snap [32];
        int id = int'(br_ckpt_id);
        if (rel) m_head = (m_head + 1) % NC;
        if (br_mispredict) begin
            m_map = m_ck[id];
            m_tail = (id + 1) % NC;
            m_count = ((id - m_head + NC) % NC) + 1;
        end
`ifdef RMT_WALK_RECOVERY_EN
        else if (walk_mode) begin
            for (int j = W-1; j >= 0; j--)
                if (walk_valid[j] && walk_arf[j] != 0) m_map[walk_arf[j]] = int'(walk_prf[j]);
            m_tail = m_head;
            m_count = 0;
        end
`endif
        else begin
            if (acc) begin
                snap = m_map;
                for (int j = 0; j < W; j++) begin
                    if (rn_valid[j] && rn_wen[j] && rn_rd[j] != 0) begin
                        m_map[rn_rd[j]] = int'(rn_new_prf[j]);
                        if (j <= int'(ckpt_slot)) snap[rn_rd[j]] = int'(rn_new_prf[j]);
                    end
                end
                if (ckpt_req) begin
                    m_ck[m_tail] = snap;
                    m_tail = (m_tail + 1) % NC;
                    m_count++;
                end
            end
            if (rel) m_count--;
        end
    endtask

    task automatic idle();
        rn_valid = '0; rn_wen = '0; rn_rd = '0; rn_rs1 = '0; rn_rs2 = '0; rn_new_prf = '0;
        ckpt_req = 1'b0; ckpt_slot = '0; br_mispredict = 1'b0; br_ckpt_id = '0; ckpt_release = 1'b0;
`ifdef RMT_WALK_RECOVERY_EN
        walk_mode = 1'b0; walk_valid = '0; walk_arf = '0; walk_prf = '0;
`endif
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic read_map(input int r, output int v);
        rn_valid = '0;
        rn_rs1[0] = AW'(r);
        #1;
        v = int'(rn_rs1_prf[0]);
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic alloc_plain(input int n);
        for (int i = 0; i < n; i++) begin
            idle(); ckpt_req = 1'b1; #1;
            checks++; if (ckpt_id !== CW'((m_tail) % NC)) begin failures++; $display("FAIL alloc_id got=%0d exp=%0d", ckpt_id, m_tail); end
            tick();
        end
    endtask

    task automatic test_reset();
        int v;
        apply_reset();
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ckpt_count); end
        checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL reset_ckpt_id got=%0d exp=0", ckpt_id); end
        checks++; if (rn_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", rn_ready); end
        for (int i = 0; i < 32; i++) begin
            read_map(i, v);
            checks++; if (v !== i) begin failures++; $display("FAIL reset_map[%0d] got=%0d exp=%0d", i, v, i); end
        end
    endtask

    task automatic test_bypass();
        int v;
        apply_reset();
        rn_valid = 2'b11; rn_wen = 2'b01; rn_rd[0] = 5'd5; rn_new_prf[0] = 6'd40; rn_rs1[1] = 5'd5; rn_rs1[0] = 5'd5;
        #1;
        checks++; if (rn_rs1_prf[1] !== 6'd40) begin failures++; $display("FAIL bypass_rs1 got=%0d exp=40", rn_rs1_prf[1]); end
        checks++; if (rn_rs1_prf[0] !== 6'd5) begin failures++; $display("FAIL bypass_slot0_rs1 got=%0d exp=5", rn_rs1_prf[0]); end
        tick(); idle(); read_map(5, v);
        checks++; if (v !== 40) begin failures++; $display("FAIL bypass_map5 got=%0d exp=40", v); end
    endtask

    task automatic test_youngest_wins();
        int v;
        idle();
        rn_valid = 2'b11; rn_wen = 2'b11; rn_rd[0] = 5'd7; rn_rd[1] = 5'd7; rn_new_prf[0] = 6'd40; rn_new_prf[1] = 6'd41;
        #1;
        checks++; if (rn_rd_stale_prf[1] !== 6'd40) begin failures++; $display("FAIL yw_stale1 got=%0d exp=40", rn_rd_stale_prf[1]); end
        checks++; if (rn_rd_stale_prf[0] !== 6'd7) begin failures++; $display("FAIL yw_stale0 got=%0d exp=7", rn_rd_stale_prf[0]); end
        tick(); idle(); read_map(7, v);
        checks++; if (v !== 41) begin failures++; $display("FAIL yw_map7 got=%0d exp=41", v); end
        rn_valid = 2'b01; rn_wen = 2'b01; rn_rd[0] = 5'd0; rn_new_prf[0] = 6'd50;
        tick(); idle(); read_map(0, v);
        checks++; if (v !== 0) begin failures++; $display("FAIL x0_map got=%0d exp=0", v); end
    endtask

    task automatic test_ckpt_restore();
        int v;
        apply_reset();
        rn_valid = 2'b11; rn_wen = 2'b10; rn_rd[1] = 5'd3; rn_new_prf[1] = 6'd44; ckpt_req = 1'b1; ckpt_slot = 1'b0;
        #1;
        checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL cr_id got=%0d exp=0", ckpt_id); end
        checks++; if (rn_ready !== 1'b1) begin failures++; $display("FAIL cr_ready got=%0b exp=1", rn_ready); end
        tick(); idle(); read_map(3, v);
        checks++; if (v !== 44) begin failures++; $display("FAIL cr_map3 got=%0d exp=44", v); end
        checks++; if (ckpt_count !== 4'd1) begin failures++; $display("FAIL cr_count got=%0d exp=1", ckpt_count); end
        br_mispredict = 1'b1; br_ckpt_id = 3'd0;
        #1;
        checks++; if (rn_ready !== 1'b0) begin failures++; $display("FAIL cr_mp_ready got=%0b exp=0", rn_ready); end
        tick(); idle(); read_map(3, v);
        checks++; if (v !== 3) begin failures++; $display("FAIL cr_restored_map3 got=%0d exp=3", v); end
        checks++; if (ckpt_count !== 4'd1) begin failures++; $display("FAIL cr_mp_count got=%0d exp=1", ckpt_count); end
        checks++; if (ckpt_id !== 3'd1) begin failures++; $display("FAIL cr_mp_tail got=%0d exp=1", ckpt_id); end
    endtask

    task automatic test_full_wrap();
        int v;
        apply_reset();
        alloc_plain(8);
        checks++; if (ckpt_count !== 4'd8) begin failures++; $display("FAIL fw_count got=%0d exp=8", ckpt_count); end
        rn_valid = 2'b01; rn_wen = 2'b01; rn_rd[0] = 5'd4; rn_new_prf[0] = 6'd33; ckpt_req = 1'b1;
        #1;
        checks++; if (rn_ready !== 1'b0) begin failures++; $display("FAIL fw_full_ready got=%0b exp=0", rn_ready); end
        tick();
        checks++; if (rn_rd_stale_prf[0] !== 6'd4) begin failures++; $display("FAIL fw_no_write got=%0d exp=4", rn_rd_stale_prf[0]); end
        checks++; if (ckpt_count !== 4'd8) begin failures++; $display("FAIL fw_hold_count got=%0d exp=8", ckpt_count); end
        ckpt_release = 1'b1;
        tick();
        ckpt_release = 1'b0;
        #1;
        checks++; if (rn_ready !== 1'b1) begin failures++; $display("FAIL fw_retry_ready got=%0b exp=1", rn_ready); end
        checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL fw_wrap_id got=%0d exp=0", ckpt_id); end
        tick(); idle(); read_map(4, v);
        checks++; if (v !== 33) begin failures++; $display("FAIL fw_map4 got=%0d exp=33", v); end
        checks++; if (ckpt_count !== 4'd8) begin failures++; $display("FAIL fw_final_count got=%0d exp=8", ckpt_count); end
    endtask

    task automatic test_mispredict_release();
        int v;
        apply_reset();
        alloc_plain(4);
        rn_valid = 2'b01; rn_wen = 2'b01; rn_rd[0] = 5'd6; rn_new_prf[0] = 6'd21;
        br_mispredict = 1'b1; br_ckpt_id = 3'd1; ckpt_release = 1'b1;
        tick(); idle(); read_map(6, v);
        checks++; if (v !== 6) begin failures++; $display("FAIL mr_dropped_map6 got=%0d exp=6", v); end
        checks++; if (ckpt_count !== 4'd1) begin failures++; $display("FAIL mr_count got=%0d exp=1", ckpt_count); end
        checks++; if (ckpt_id !== 3'd2) begin failures++; $display("FAIL mr_tail got=%0d exp=2", ckpt_id); end
        ckpt_release = 1'b1; tick(); tick(); ckpt_release = 1'b0;
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL mr_release_empty got=%0d exp=0", ckpt_count); end
    endtask

    task automatic test_reset_mid_restore();
        int v;
        apply_reset();
        rn_valid = 2'b01; rn_wen = 2'b01; rn_rd[0] = 5'd3; rn_new_prf[0] = 6'd30; ckpt_req = 1'b1;
        tick(); idle();
        br_mispredict = 1'b1; br_ckpt_id = 3'd0;
        #1; rst = 1'b1; #1;
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL rmr_count got=%0d exp=0", ckpt_count); end
        checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL rmr_tail got=%0d exp=0", ckpt_id); end
        br_mispredict = 1'b0;
        read_map(3, v);
        checks++; if (v !== 3) begin failures++; $display("FAIL rmr_map3 got=%0d exp=3", v); end
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            idle();
            rn_valid = W'($urandom); rn_wen = W'($urandom);
            for (int k = 0; k < W; k++) begin
                rn_rd[k] = AW'($urandom_range(0, 7)); rn_rs1[k] = AW'($urandom_range(0, 7));
                rn_rs2[k] = AW'($urandom_range(0, 7)); rn_new_prf[k] = PW'($urandom);
            end
            ckpt_req = ($urandom % 3) == 0;
            ckpt_slot = 1'($urandom);
            ckpt_release = ($urandom % 4) == 0;
            br_mispredict = (m_count > 0) && (($urandom % 10) == 0);
            if (br_mispredict) begin
                if (ckpt_release && m_count < 2) ckpt_release = 1'b0;
                if (ckpt_release) br_ckpt_id = CW'((m_head + 1 + $urandom % (m_count - 1)) % NC);
                else br_ckpt_id = CW'((m_head + $urandom % m_count) % NC);
            end
            #1;
            checks++; if (rn_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready c=%0d got=%0b exp=%0b", c, rn_ready, exp_ready()); end
            checks++; if (ckpt_id !== CW'(m_tail)) begin failures++; $display("FAIL rand_ckpt_id c=%0d got=%0d exp=%0d", c, ckpt_id, m_tail); end
            checks++; if (ckpt_count !== 4'(m_count)) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, ckpt_count, m_count); end
            for (int k = 0; k < W; k++) begin
                checks++; if (rn_rs1_prf[k] !== PW'(exp_lookup(k, int'(rn_rs1[k])))) begin failures++; $display("FAIL rand_rs1 c=%0d k=%0d got=%0d exp=%0d", c, k, rn_rs1_prf[k], exp_lookup(k, int'(rn_rs1[k]))); end
                checks++; if (rn_rs2_prf[k] !== PW'(exp_lookup(k, int'(rn_rs2[k])))) begin failures++; $display("FAIL rand_rs2 c=%0d k=%0d got=%0d exp=%0d", c, k, rn_rs2_prf[k], exp_lookup(k, int'(rn_rs2[k]))); end
                checks++; if (rn_rd_stale_prf[k] !== PW'(exp_lookup(k, int'(rn_rd[k])))) begin failures++; $display("FAIL rand_stale c=%0d k=%0d got=%0d exp=%0d", c, k, rn_rd_stale_prf[k], exp_lookup(k, int'(rn_rd[k]))); end
            end
            tick();
        end
        idle();
    endtask

`ifdef RMT_WALK_RECOVERY_EN
    task automatic test_walk();
        int v;
        apply_reset();
        alloc_plain(2);
        walk_mode = 1'b1; walk_valid = 2'b11; walk_arf[0] = 5'd9; walk_arf[1] = 5'd9;
        walk_prf[0] = 6'd12; walk_prf[1] = 6'd20;
        #1;
        checks++; if (rn_ready !== 1'b0) begin failures++; $display("FAIL walk_ready got=%0b exp=0", rn_ready); end
        tick(); idle(); read_map(9, v);
        checks++; if (v !== 12) begin failures++; $display("FAIL walk_map9 got=%0d exp=12", v); end
        checks++; if (ckpt_count !== 4'd0) begin failures++; $display("FAIL walk_count got=%0d exp=0", ckpt_count); end
        checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL walk_tail got=%0d exp=0", ckpt_id); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_youngest_wins();
        test_ckpt_restore();
        test_full_wrap();
        test_mispredict_release();
        test_reset_mid_restore();
`ifdef RMT_WALK_RECOVERY_EN
        test_walk();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
